// File: rtl/mult_accum.sv
// mult_accum -- signed frame accumulator behind the 18x18 registered multiplier.
//
// Sums LEN consecutive accepted products into one ACC_W-bit frame result,
// optionally saturating on overflow, and holds it in a valid/ready output
// register.
//
// Ports
//   C      in   clock, rising edge
//   R      in   synchronous active-low reset
//   CE     in   input-side enable; when low the accumulator, counter and
//               frame flag hold (the output pop still works)
//   P      in   signed product, PROD_W bits
//   P_VLD  in   P valid this cycle
//   P_RDY  out  stage accepts P this cycle (combinational from S_RDY)
//   S      out  signed frame result, ACC_W bits
//   S_VLD  out  S holds an unconsumed result
//   S_RDY  in   downstream accepts S
//   OVF    out  overflow occurred in the frame now held in S
module mult_accum #(
   parameter int PROD_W = 36,
   parameter int ACC_W  = 48,
   parameter int LEN    = 16,
   parameter int SAT    = 1
) (
   input  logic              C,
   input  logic              R,
   input  logic              CE,
   input  logic [PROD_W-1:0] P,
   input  logic              P_VLD,
   output logic              P_RDY,
   output logic [ACC_W-1:0]  S,
   output logic              S_VLD,
   input  logic              S_RDY,
   output logic              OVF
);

   localparam int              CW   = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0]   LAST = CW'(LEN - 1);
   localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {EMPTY, FULL} ostate_t;

   ostate_t          state_q, state_d;
   logic [CW-1:0]    cnt;
   logic [ACC_W-1:0] acc;
   logic             fovf;

   logic             last, acc_en, done;
   logic [ACC_W:0]   p_ext, acc_ext, sum;
   logic             ovf_hi, ovf_lo;
   logic [ACC_W-1:0] nxt_acc;
   logic             nxt_fovf;

   assign last   = (cnt == LAST);
   // Only the product that would complete a frame stalls; it cannot land
   // while the previous result is still unconsumed.
   assign P_RDY  = !(last && (state_q == FULL) && !S_RDY);
   assign acc_en = CE && P_VLD && P_RDY;
   assign done   = acc_en && last;
   assign S_VLD  = (state_q == FULL);

   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign p_ext   = {{(ACC_W+1-PROD_W){P[PROD_W-1]}}, P};
   assign acc_ext = {acc[ACC_W-1], acc};
   assign sum     = acc_ext + p_ext;
   assign ovf_hi  = !sum[ACC_W] &&  sum[ACC_W-1];
   assign ovf_lo  =  sum[ACC_W] && !sum[ACC_W-1];

   always_comb begin
      nxt_acc  = sum[ACC_W-1:0];
      nxt_fovf = fovf || ovf_hi || ovf_lo;
      if (cnt == '0) begin
         // first product of a frame restarts the sum and the flag
         nxt_acc  = p_ext[ACC_W-1:0];
         nxt_fovf = 1'b0;
      end else if (SAT != 0 && ovf_hi) begin
         nxt_acc = MAX_V;
      end else if (SAT != 0 && ovf_lo) begin
         nxt_acc = MIN_V;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (done) state_d = FULL;
         FULL:  if (S_RDY && !done) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge C) begin
      if (!R) begin
         state_q <= EMPTY;
         cnt     <= '0;
         acc     <= '0;
         fovf    <= 1'b0;
         S       <= '0;
         OVF     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (acc_en) begin
            acc  <= nxt_acc;
            fovf <= nxt_fovf;
            cnt  <= last ? '0 : cnt + CW'(1);
         end
         if (done) begin
            S   <= nxt_acc;
            OVF <= nxt_fovf;
         end
      end
   end

endmodule

// File: tb/tb_mult_accum.sv
module tb_mult_accum;

   localparam int LEN = 4;

   logic        c, r, ce, p_vld, s_rdy;
   logic [35:0] p;
   logic [47:0] s0;
   logic [36:0] s1, s2;
   logic        vld0, vld1, vld2, ovf0, ovf1, ovf2, prdy0, prdy1, prdy2;

   int checks   = 0;
   int failures = 0;

   // d0: wide accumulator; d1: 37-bit saturating; d2: 37-bit wrapping
   mult_accum #(.PROD_W(36), .ACC_W(48), .LEN(LEN), .SAT(1)) d0 (
      .C(c), .R(r), .CE(ce), .P(p), .P_VLD(p_vld), .P_RDY(prdy0),
      .S(s0), .S_VLD(vld0), .S_RDY(s_rdy), .OVF(ovf0));
   mult_accum #(.PROD_W(36), .ACC_W(37), .LEN(LEN), .SAT(1)) d1 (
      .C(c), .R(r), .CE(ce), .P(p), .P_VLD(p_vld), .P_RDY(prdy1),
      .S(s1), .S_VLD(vld1), .S_RDY(s_rdy), .OVF(ovf1));
   mult_accum #(.PROD_W(36), .ACC_W(37), .LEN(LEN), .SAT(0)) d2 (
      .C(c), .R(r), .CE(ce), .P(p), .P_VLD(p_vld), .P_RDY(prdy2),
      .S(s2), .S_VLD(vld2), .S_RDY(s_rdy), .OVF(ovf2));

   initial begin
      c = 1'b0;
      forever #5 c = ~c;
   end

   // Reference model: products of the open frame are kept in a queue and the
   // frame result is folded from it only when the frame is complete.
   int     aw[3]   = '{48, 37, 37};
   bit     satv[3] = '{1'b1, 1'b1, 1'b0};
   longint fq[$];
   bit     m_vld;
   longint m_s[3];
   bit     m_ovf[3];

   function automatic bit m_prdy();
      return !((fq.size() == LEN - 1) && m_vld && !s_rdy);
   endfunction

   function automatic void fold(input int w, input bit sat, output longint res, output bit ovf);
      longint hi, lo, sum;
      hi  = (longint'(1) <<< (w - 1)) - 1;
      lo  = -(longint'(1) <<< (w - 1));
      res = 0;
      ovf = 1'b0;
      foreach (fq[i]) begin
         if (i == 0) res = fq[i];
         else begin
            sum = res + fq[i];
            if (sum > hi) begin
               ovf = 1'b1;
               res = sat ? hi : sum - 2 * (hi + 1);
            end else if (sum < lo) begin
               ovf = 1'b1;
               res = sat ? lo : sum + 2 * (hi + 1);
            end else res = sum;
         end
      end
   endfunction

   always @(posedge c) begin
      bit take, pop;
      if (!r) begin
         fq.delete();
         m_vld = 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_s[k]   = 0;
            m_ovf[k] = 1'b0;
         end
      end else begin
         take = ce && p_vld && m_prdy();
         pop  = m_vld && s_rdy;
         if (take) fq.push_back(longint'($signed(p)));
         if (take && fq.size() == LEN) begin
            for (int k = 0; k < 3; k++) fold(aw[k], satv[k], m_s[k], m_ovf[k]);
            m_vld = 1'b1;
            fq.delete();
         end else if (pop) m_vld = 1'b0;
      end
   end

   task automatic drive(input bit ce_i, input bit vld_i, input logic [35:0] p_i, input bit srdy_i);
      ce    = ce_i;
      p_vld = vld_i;
      p     = p_i;
      s_rdy = srdy_i;
   endtask

   task automatic tick();
      @(posedge c);
      @(negedge c);
   endtask

   task automatic test_reset();
      r = 1'b0;
      drive(1'b1, 1'b1, 36'd5, 1'b1);
      tick();
      tick();
      checks++;
      if (s0 !== 48'd0 || vld0 !== 1'b0 || ovf0 !== 1'b0 || prdy0 !== 1'b1) begin
         failures++;
         $display("FAIL reset: S=%h S_VLD=%b OVF=%b P_RDY=%b, want 0 0 0 1", s0, vld0, ovf0, prdy0);
      end
      r = 1'b1;
      drive(1'b1, 1'b0, 36'd0, 1'b1);
      tick();
      checks++;
      if (vld0 !== 1'b0 || s0 !== 48'd0 || prdy0 !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: S=%h S_VLD=%b P_RDY=%b, want 0 0 1", s0, vld0, prdy0);
      end
   endtask

   task automatic test_basic();
      logic [35:0] bp[4];
      bp[0] = 36'hFFFFFFFFB;
      bp[1] = 36'd3;
      bp[2] = 36'h000004000;
      bp[3] = 36'hFFFFFFFFE;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, bp[i], 1'b1);
         tick();
         checks++;
         if (vld0 !== (i == 3)) begin
            failures++;
            $display("FAIL basic_vld[%0d]: S_VLD=%b want %b", i, vld0, (i == 3));
         end
      end
      checks++;
      if (s0 !== 48'h000000003FFC || ovf0 !== 1'b0 || longint'($signed(s0)) !== m_s[0]) begin
         failures++;
         $display("FAIL basic_sum: S=%h OVF=%b want 000000003ffc 0", s0, ovf0);
      end
      drive(1'b1, 1'b0, 36'd0, 1'b1);
      tick();
      checks++;
      if (vld0 !== 1'b0) begin
         failures++;
         $display("FAIL basic_one_cycle: S_VLD=%b want 0", vld0);
      end
   endtask

   task automatic test_backpressure();
      bit exp_rdy;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 36'd1, 1'b0);
         tick();
         exp_rdy = (i < 6);
         checks++;
         if (prdy0 !== exp_rdy || prdy0 !== m_prdy() || vld0 !== (i >= 3) || vld0 !== m_vld) begin
            failures++;
            $display("FAIL bp_cycle[%0d]: P_RDY=%b S_VLD=%b want %b %b", i, prdy0, vld0, exp_rdy, (i >= 3));
         end
         if (i >= 3) begin
            checks++;
            if (s0 !== 48'd4) begin
               failures++;
               $display("FAIL bp_hold[%0d]: S=%h want 4", i, s0);
            end
         end
      end
      drive(1'b1, 1'b1, 36'd1, 1'b1);
      #1;
      checks++;
      if (prdy0 !== 1'b1) begin
         failures++;
         $display("FAIL bp_comb_rdy: P_RDY=%b want 1", prdy0);
      end
      tick();
      checks++;
      if (vld0 !== 1'b1 || s0 !== 48'd4 || ovf0 !== 1'b0) begin
         failures++;
         $display("FAIL bp_coincide: S=%h S_VLD=%b OVF=%b want 4 1 0", s0, vld0, ovf0);
      end
      drive(1'b1, 1'b0, 36'd0, 1'b1);
      tick();
      checks++;
      if (vld0 !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain: S_VLD=%b want 0", vld0);
      end
   endtask

   task automatic test_saturation();
      logic [35:0] v[3];
      logic [36:0] want_s[3];
      bit          want_o[3];
      v[0] = 36'h7FFFFFFFF; want_s[0] = 37'h0FFFFFFFFF; want_o[0] = 1'b1;
      v[1] = 36'h800000000; want_s[1] = 37'h1000000000; want_o[1] = 1'b1;
      v[2] = 36'd1;         want_s[2] = 37'd4;          want_o[2] = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, v[f], 1'b1);
            tick();
         end
         checks++;
         if (vld1 !== 1'b1 || s1 !== want_s[f] || ovf1 !== want_o[f]) begin
            failures++;
            $display("FAIL sat_frame[%0d]: S=%h S_VLD=%b OVF=%b want %h 1 %b", f, s1, vld1, ovf1, want_s[f], want_o[f]);
         end
         checks++;
         if (longint'($signed(s0)) !== m_s[0] || ovf0 !== m_ovf[0] ||
             longint'($signed(s2)) !== m_s[2] || ovf2 !== m_ovf[2]) begin
            failures++;
            $display("FAIL sat_others[%0d]: S48=%h OVF=%b S37w=%h OVF=%b want %h %b %h %b", f,
                     s0, ovf0, s2, ovf2, m_s[0], m_ovf[0], m_s[2], m_ovf[2]);
         end
      end
      drive(1'b1, 1'b0, 36'd0, 1'b1);
      tick();
   endtask

   task automatic test_ce_stall();
      drive(1'b1, 1'b1, 36'd1, 1'b1); tick();
      drive(1'b1, 1'b1, 36'd2, 1'b1); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 36'd100, 1'b1);
         tick();
         checks++;
         if (vld0 !== 1'b0) begin
            failures++;
            $display("FAIL ce_hold[%0d]: S_VLD=%b want 0", i, vld0);
         end
      end
      drive(1'b1, 1'b1, 36'd3, 1'b1); tick();
      drive(1'b1, 1'b1, 36'd4, 1'b1); tick();
      checks++;
      if (vld0 !== 1'b1 || s0 !== 48'd10 || ovf0 !== 1'b0) begin
         failures++;
         $display("FAIL ce_sum: S=%h S_VLD=%b OVF=%b want 10 1 0", s0, vld0, ovf0);
      end
   endtask

   task automatic test_midreset();
      drive(1'b1, 1'b1, 36'd7, 1'b1); tick();
      drive(1'b1, 1'b1, 36'd7, 1'b1); tick();
      r = 1'b0;
      tick();
      r = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 36'd1, 1'b1);
         tick();
         checks++;
         if (vld0 !== (i == 3)) begin
            failures++;
            $display("FAIL midreset_vld[%0d]: S_VLD=%b want %b", i, vld0, (i == 3));
         end
      end
      checks++;
      if (s0 !== 48'd4 || ovf0 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_sum: S=%h OVF=%b want 4 0", s0, ovf0);
      end
      drive(1'b1, 1'b0, 36'd0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      longint got_s[3];
      bit     got_v[3], got_o[3], got_r[3];
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(63) != 0);
         drive($urandom_range(9) != 0, $urandom_range(3) != 0,
               {$urandom_range(15), $urandom()}, $urandom_range(2) != 0);
         #1;
         checks++;
         if (prdy0 !== m_prdy() || prdy1 !== m_prdy() || prdy2 !== m_prdy()) begin
            failures++;
            $display("FAIL rand_prdy[%0d]: P_RDY=%b%b%b want %b", n, prdy0, prdy1, prdy2, m_prdy());
         end
         tick();
         got_s[0] = longint'($signed(s0)); got_v[0] = vld0; got_o[0] = ovf0; got_r[0] = prdy0;
         got_s[1] = longint'($signed(s1)); got_v[1] = vld1; got_o[1] = ovf1; got_r[1] = prdy1;
         got_s[2] = longint'($signed(s2)); got_v[2] = vld2; got_o[2] = ovf2; got_r[2] = prdy2;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_v[k] !== m_vld || got_s[k] !== m_s[k] || got_o[k] !== m_ovf[k] || got_r[k] !== m_prdy()) begin
               failures++;
               $display("FAIL rand[%0d] dut%0d: S=%0d V=%b O=%b R=%b want %0d %b %b %b", n, k,
                        got_s[k], got_v[k], got_o[k], got_r[k], m_s[k], m_vld, m_ovf[k], m_prdy());
            end
         end
      end
      r = 1'b1;
   endtask

   initial begin
      r = 1'b0;
      drive(1'b0, 1'b0, 36'd0, 1'b0);
      @(negedge c);
      test_reset();
      test_basic();
      test_backpressure();
      test_saturation();
      test_ce_stall();
      test_midreset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_accum.md
# mult_accum

Signed accumulate stage placed directly downstream of the 18x18 registered multiplier. It consumes the 36-bit signed product `P`, sums `LEN` consecutive accepted products into one frame result with optional saturation, and presents that result through a valid/ready output register. `P_RDY` back-pressures upstream and is intended to gate the multiplier's `CE`.

## Interface
- `PROD_W`, 36: product width (signed).
- `ACC_W`, 48: accumulator and result width (signed). Must be ≥ `PROD_W`.
- `LEN`, 16: products per frame. Must be ≥ 1.
- `SAT`, 1: 1 = saturate on overflow; 0 = wrap two's-complement.
- `C`, in, 1: clock. All logic is on the rising edge.
- `R`, in, 1: reset, synchronous, active-low.
- `CE`, in, 1: input-side clock enable. When 0, the accumulator, counter and frame flag hold.
- `P`, in, `PROD_W`: signed product from the multiplier.
- `P_VLD`, in, 1: `P` is valid this cycle.
- `P_RDY`, out, 1: stage can accept `P` this cycle.
- `S`, out, `ACC_W`: frame result, signed.
- `S_VLD`, out, 1: `S` holds an unconsumed result.
- `S_RDY`, in, 1: downstream accepts `S`.
- `OVF`, out, 1: saturation or wrap occurred in the frame now in `S`.

## Operation
- Accept condition: `acc_en = CE & P_VLD & P_RDY`.
- Frame counter `cnt` runs 0..`LEN`-1 and increments on each `acc_en`. It wraps to 0 after `LEN`-1.
- Sign extension: `P` is sign-extended to `ACC_W`+1 bits before the add.
- First product (`cnt`==0): `acc` ← `P`, and the frame overflow flag `fovf` is set to 0. The previous `acc` is discarded.
- Later products: `sum` = `acc` + `P`, computed at `ACC_W`+1 bits.
  - Overflow means `sum` lies outside [−2^(`ACC_W`−1), 2^(`ACC_W`−1)−1].
  - When `SAT`=1, an overflowing `sum` clamps to the nearest bound.
  - When `SAT`=0, `sum` is truncated to `ACC_W` bits.
  - Any overflow sets `fovf`, which stays set until the frame ends.
  - The following add uses the clamped (or wrapped) value.
- Frame complete: on `acc_en` with `cnt`==`LEN`-1.
  - The final `acc` value (including this product) loads into `S`.
  - The final `fovf` loads into `OVF`.
  - `S_VLD` is set to 1.
  - When `LEN`=1, every accepted product completes a frame.
- Output register states:
  - EMPTY (`S_VLD`=0) → FULL on frame complete.
  - FULL → EMPTY on `S_VLD & S_RDY` when no frame completes in the same cycle.
  - FULL stays FULL with new `S` and `OVF` when a pop and a frame complete coincide.
- Back-pressure: `P_RDY` = !(`cnt`==`LEN`-1 & `S_VLD` & !`S_RDY`).
  - This is combinational from `S_RDY`.
  - Only the completing product is ever stalled; earlier products of the next frame are accepted while `S` waits.
- `CE`=0: `P_VLD` is ignored and no input state changes. The output handshake (pop) still operates.
- Reset (`R`=0 at a rising `C`) takes priority over everything:
  - `acc`=0, `cnt`=0, `fovf`=0, `S`=0, `S_VLD`=0, `OVF`=0.
  - Any partial frame is discarded.

## Timing
- Reset values: `S`=0, `S_VLD`=0, `OVF`=0. `P_RDY`=1 from the first cycle after reset.
- Latency: `S`/`S_VLD`/`OVF` update at the rising edge that accepts the `LEN`-th product. They are visible in the following cycle, one cycle after that product was presented.
- Throughput: one product per cycle sustained while `S_RDY`=1. Back-to-back frames have no bubble.
- `S` and `OVF` are stable while `S_VLD`=1 and `S_RDY`=0.
- `R` deasserted with `CE`=1: the first product may be accepted in the first cycle after reset.

## Test plan
- Reset: hold `R`=0 two cycles with `P_VLD`=1 → `S`=0, `S_VLD`=0, `OVF`=0, `P_RDY`=1; no accumulation.
- Basic signed frame, `LEN`=4, `S_RDY`=1:
  - `P` = −5 (36'hFFFFFFFFB), 3, 36'h000004000, −2 → `S`=48'h000000003FFC, `OVF`=0.
  - `S_VLD` is high exactly one cycle, one cycle after the last product.
- Back-pressure, `LEN`=4, `S_RDY`=0, `P`=1 continuously:
  - First `S`=4, `S_VLD` held.
  - Three more products accepted, then `P_RDY`=0 with `cnt`=3.
  - Raise `S_RDY` → pop and completion coincide; `S`=4 again, `S_VLD` stays 1.
- Saturation, `ACC_W`=37, `LEN`=4, `SAT`=1:
  - `P` = 36'h7FFFFFFFF ×4 → `S`=37'h0FFFFFFFFF, `OVF`=1.
  - `P` = 36'h800000000 ×4 → `S`=37'h1000000000, `OVF`=1.
  - Next frame `P`=1 ×4 → `S`=4, `OVF`=0.
- `CE` stall, `LEN`=4:
  - `P` = 1, 2, then `CE`=0 for 3 cycles with `P_VLD`=1 and `P`=100, then `CE`=1 with `P` = 3, 4 → `S`=10.
- Mid-frame reset, `LEN`=4:
  - Accept 7, 7, pulse `R`=0 one cycle, then accept 1, 1, 1, 1 → `S`=4, `OVF`=0.
  - No `S_VLD` before the fourth post-reset product.
